// File: rtl/stm32_if_pkg.sv
// stm32_if_pkg: command codes, status bit layout and FSM states for the STM32 nibble link
package stm32_if_pkg;
    localparam logic [3:0] CMD_CODE_PARAMS = 4'd1;
    localparam logic [3:0] CMD_CODE_STATUS = 4'd2;
    localparam logic [3:0] CMD_CODE_TX_IQ  = 4'd3;
    localparam logic [3:0] CMD_CODE_RX_IQ  = 4'd4;
    localparam int         STAT_OTR        = 0;
    localparam int         STAT_OVF        = 1;
    localparam int         STAT_UDR        = 2;
    localparam int         NIBS_PER_IQ     = 8;
    localparam logic [2:0] LAST_NIB        = 3'(NIBS_PER_IQ - 1);
    typedef enum logic [1:0] {ST_IDLE, ST_SEND_IQ, ST_SEND_STAT} state_t;
endpackage

// File: rtl/iq_sync_fifo.sv
// iq_sync_fifo: single-clock FIFO with registered flags; push+pop when full is accepted
module iq_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_level, w_level_n;
    logic             r_full, r_empty, w_push, w_pop;
    assign w_push    = i_push & (~r_full | i_pop);
    assign w_pop     = i_pop & ~r_empty;
    assign w_level_n = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign o_rdata   = r_mem[r_rd];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_level   = r_level;
    // storage write; contents need no reset since pointers define validity
    always_ff @(posedge i_clk)
        if (w_push) r_mem[r_wr] <= i_wdata;
    // pointers and occupancy flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_level <= w_level_n;
            r_full  <= w_level_n == (AW+1)'(DEPTH);
            r_empty <= w_level_n == '0;
        end
    end
endmodule

// File: rtl/stm32_iq_scheduler.sv
// stm32_iq_scheduler: buffers DDC I/Q samples and serves them nibble-serially to the STM32
module stm32_iq_scheduler
    import stm32_if_pkg::*;
#(
    parameter  int         FIFO_DEPTH = 16,
    parameter  logic [3:0] CMD_STATUS = CMD_CODE_STATUS,
    parameter  logic [3:0] CMD_RX_IQ  = CMD_CODE_RX_IQ,
    localparam int         LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               iq_valid,
    input  logic signed [15:0] I,
    input  logic signed [15:0] Q,
    input  logic               ADC_OTR,
    input  logic               DATA_SYNC,
    input  logic [3:0]         DATA_IN,
    output logic [3:0]         DATA_OUT,
    output logic               iq_avail,
    output logic [LW-1:0]      fifo_level
);
    state_t        r_state, w_state_n;
    logic          r_pend_iq, r_pend_stat;
    logic [31:0]   r_hold, w_hold_n, w_hold_sh, w_head;
    logic [2:0]    r_cnt, w_cnt_n;
    logic [3:0]    r_data_out, w_out_n, w_status;
    logic          r_ovf, r_udr, r_otr, w_clr, w_udr_evt;
    logic          w_pop, w_full, w_empty, r_avail;
    logic [LW-1:0] w_level, r_level;
    iq_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst),
        .i_push  (iq_valid),
        .i_pop   (w_pop),
        .i_wdata ({Q, I}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );
    // a strobe in the same cycle as a pending RX-IQ supersedes it, so no pop then
    assign w_pop      = r_pend_iq & ~DATA_SYNC & ~w_empty;
    assign w_hold_sh  = r_hold << {r_cnt, 2'b00};
    assign DATA_OUT   = r_data_out;
    assign iq_avail   = r_avail;
    assign fifo_level = r_level;
    // status nibble assembled from the sticky flags
    always_comb begin
        w_status           = '0;
        w_status[STAT_OTR] = r_otr;
        w_status[STAT_OVF] = r_ovf;
        w_status[STAT_UDR] = r_udr;
    end
    // next state and next nibble; a fresh strobe aborts whatever is in flight
    always_comb begin
        w_state_n = ST_IDLE;
        w_out_n   = 4'd0;
        w_hold_n  = r_hold;
        w_cnt_n   = r_cnt;
        w_clr     = 1'b0;
        w_udr_evt = 1'b0;
        if (DATA_SYNC) begin
            w_state_n = ST_IDLE;
        end else if (r_pend_iq) begin
            w_state_n = ST_SEND_IQ;
            w_hold_n  = w_empty ? 32'd0 : w_head;
            w_out_n   = w_hold_n[31:28];
            w_cnt_n   = 3'd1;
            w_udr_evt = w_empty;
        end else if (r_pend_stat) begin
            w_state_n = ST_SEND_STAT;
            w_out_n   = w_status;
            w_clr     = 1'b1;
        end else if (r_state == ST_SEND_IQ) begin
            w_state_n = (r_cnt == LAST_NIB) ? ST_IDLE : ST_SEND_IQ;
            w_out_n   = w_hold_sh[31:28];
            w_cnt_n   = r_cnt + 3'd1;
        end
    end
    // state, decoded command, sticky flags and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pend_iq   <= 1'b0;
            r_pend_stat <= 1'b0;
            r_hold      <= '0;
            r_cnt       <= '0;
            r_data_out  <= '0;
            r_ovf       <= 1'b0;
            r_udr       <= 1'b0;
            r_otr       <= 1'b0;
            r_avail     <= 1'b0;
            r_level     <= '0;
        end else begin
            r_state     <= w_state_n;
            r_pend_iq   <= DATA_SYNC && DATA_IN == CMD_RX_IQ;
            r_pend_stat <= DATA_SYNC && DATA_IN == CMD_STATUS;
            r_hold      <= w_hold_n;
            r_cnt       <= w_cnt_n;
            r_data_out  <= w_out_n;
            r_ovf       <= (r_ovf & ~w_clr) | (iq_valid & w_full & ~w_pop);
            r_udr       <= (r_udr & ~w_clr) | w_udr_evt;
            r_otr       <= (r_otr & ~w_clr) | ADC_OTR;
            r_avail     <= ~w_empty;
            r_level     <= w_level;
        end
    end
endmodule

// File: tb/tb_stm32_iq_scheduler.sv
// tb_stm32_iq_scheduler: randomized bench against a transaction-level queue model
module tb_stm32_iq_scheduler;
    localparam int         DEPTH   = 16;
    localparam logic [3:0] C_STAT  = 4'd2;
    localparam logic [3:0] C_RX    = 4'd4;
    logic        clk_in = 1'b0;
    logic        rst = 1'b1, iq_valid = 1'b0, ADC_OTR = 1'b0, DATA_SYNC = 1'b0;
    logic [15:0] I = '0, Q = '0;
    logic [3:0]  DATA_IN = '0, DATA_OUT;
    logic        iq_avail;
    logic [4:0]  fifo_level;
    int          n_checks = 0, n_fail = 0;
    logic [31:0] m_q [$];
    bit          m_ovf = 0, m_udr = 0, m_otr = 0;

    always #5 clk_in = ~clk_in;

    stm32_iq_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .iq_valid   (iq_valid),
        .I          (I),
        .Q          (Q),
        .ADC_OTR    (ADC_OTR),
        .DATA_SYNC  (DATA_SYNC),
        .DATA_IN    (DATA_IN),
        .DATA_OUT   (DATA_OUT),
        .iq_avail   (iq_avail),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [15:0] i, input logic [15:0] q);
        iq_valid = 1'b1; I = i; Q = q;
        tick();
        iq_valid = 1'b0;
        if (m_q.size() < DEPTH) m_q.push_back({q, i});
        else m_ovf = 1;
    endtask

    task automatic check_level();
        chk("level", 32'(fifo_level), 32'(m_q.size()));
        chk("avail", 32'(iq_avail), 32'(m_q.size() != 0));
    endtask

    task automatic cmd(input logic [3:0] c);
        DATA_SYNC = 1'b1; DATA_IN = c;
        tick();
        DATA_SYNC = 1'b0; DATA_IN = '0;
    endtask

    task automatic rx_read();
        logic [31:0] e;
        if (m_q.size() == 0) begin
            e = '0;
            m_udr = 1;
        end else e = m_q.pop_front();
        cmd(C_RX);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rx_nib", 32'(DATA_OUT), (e >> (28 - 4*k)) & 32'hF);
            if (k == 1) check_level();
        end
        tick();
        chk("rx_end", 32'(DATA_OUT), 32'd0);
    endtask

    task automatic stat_read();
        logic [31:0] e;
        e = {29'd0, m_udr, m_ovf, m_otr | ADC_OTR};
        cmd(C_STAT);
        tick();
        chk("stat", 32'(DATA_OUT), e);
        m_udr = 0; m_ovf = 0; m_otr = ADC_OTR;
        tick();
        chk("stat_end", 32'(DATA_OUT), 32'd0);
    endtask

    initial begin
        logic [3:0]  oc;
        logic [31:0] a;
        tick(); tick();
        chk("rst_out", 32'(DATA_OUT), 32'd0);
        chk("rst_avail", 32'(iq_avail), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        tick();
        push(16'h1234, 16'hABCD);
        tick();
        check_level();
        rx_read();
        rx_read();
        stat_read();
        stat_read();
        for (int n = 0; n < 17; n++) push(16'($urandom), 16'($urandom));
        tick();
        check_level();
        stat_read();
        for (int n = 0; n < 16; n++) rx_read();
        ADC_OTR = 1'b1; tick(); ADC_OTR = 1'b0; m_otr = 1;
        stat_read();
        ADC_OTR = 1'b1;
        stat_read();
        ADC_OTR = 1'b0;
        stat_read();
        stat_read();
        push(16'h5A5A, 16'hC3C3);
        push(16'h0F0F, 16'h9696);
        tick();
        a = m_q.pop_front();
        cmd(C_RX);
        tick(); chk("abort_n0", 32'(DATA_OUT), 32'(a[31:28]));
        tick(); chk("abort_n1", 32'(DATA_OUT), 32'(a[27:24]));
        cmd(C_STAT);
        chk("abort_gap", 32'(DATA_OUT), 32'd0);
        tick(); chk("abort_stat", 32'(DATA_OUT), {29'd0, m_udr, m_ovf, m_otr});
        m_udr = 0; m_ovf = 0; m_otr = 0;
        tick(); chk("abort_end", 32'(DATA_OUT), 32'd0);
        rx_read();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    for (int j = $urandom_range(1, 6); j > 0; j--) push(16'($urandom), 16'($urandom));
                    tick();
                    check_level();
                end
                1: rx_read();
                2: stat_read();
                default: begin
                    do oc = 4'($urandom_range(0, 15)); while (oc == C_STAT || oc == C_RX);
                    cmd(oc);
                    tick();
                    chk("other_cmd", 32'(DATA_OUT), 32'd0);
                end
            endcase
        end
        while (m_q.size() > 0) rx_read();
        for (int n = 0; n < 5; n++) push(16'($urandom), 16'($urandom));
        tick();
        check_level();
        cmd(C_RX);
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_q.delete();
        m_ovf = 0; m_udr = 0; m_otr = 0;
        chk("rst_mid_out", 32'(DATA_OUT), 32'd0);
        chk("rst_mid_level", 32'(fifo_level), 32'd0);
        chk("rst_mid_avail", 32'(iq_avail), 32'd0);
        tick();
        chk("rst_mid_idle", 32'(DATA_OUT), 32'd0);
        stat_read();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stm32_iq_scheduler.md
# stm32_iq_scheduler

Buffers RX I/Q samples from the DDC and schedules their nibble-serial transfer to the STM32 over the 4-bit parallel bus. Decodes STM32 command strobes, pops one sample per RX-IQ command, and reports sticky overflow, underrun and ADC over-range status on request. Sits between the DDC output and the STM32 pins. Decouples the DDC sample rate from STM32 polling jitter.

## Interface
Parameters:
- FIFO_DEPTH, 16: sample buffer depth; must be a power of 2, ≥ 4.
- CMD_STATUS, 4'd2: command code for the status read.
- CMD_RX_IQ, 4'd4: command code for the RX I/Q read.

Ports:
- clk_in  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- iq_valid  in  1  one-cycle strobe; I/Q carry a new DDC sample.
- I  in  16  signed RX in-phase sample.
- Q  in  16  signed RX quadrature sample.
- ADC_OTR  in  1  ADC over-range, level.
- DATA_SYNC  in  1  STM32 command strobe; DATA_IN holds the command code.
- DATA_IN  in  4  STM32 command nibble.
- DATA_OUT  out  4  registered nibble to the STM32.
- iq_avail  out  1  registered; high when the FIFO is non-empty (STM32 interrupt line).
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
Reset values: DATA_OUT=0, iq_avail=0, fifo_level=0, FIFO empty, all sticky flags 0, state IDLE.

Sample capture:
- When iq_valid=1, push {Q,I} (32 bits).
- If the FIFO is full and no pop occurs in the same cycle, drop the sample, leave the FIFO unchanged and set sticky ovf.
- Push and pop in the same cycle are always accepted, including when the FIFO is full; the level is unchanged.

State machine: IDLE, SEND_IQ, SEND_STAT.
- In any state, DATA_SYNC=1 with DATA_IN=CMD_RX_IQ:
  - If non-empty: pop the head, latch it into a 32-bit hold register, set nib_cnt=0, go to SEND_IQ.
  - If empty: hold=0, set sticky udr, go to SEND_IQ.
- In any state, DATA_SYNC=1 with DATA_IN=CMD_STATUS: latch status and go to SEND_STAT.
  - Status nibble = {1'b0, udr, ovf, otr_s}.
  - Clear ovf, udr and otr_s in the same cycle; an event in that same cycle re-sets its flag, so it is not lost.
- DATA_SYNC=1 with any other code: go to IDLE and drive DATA_OUT=0.
- A command arriving mid-transfer aborts the transfer. The partially sent sample is discarded and the new command is serviced.
- SEND_IQ:
  - DATA_OUT = hold[31-4n:28-4n] for n = nib_cnt.
  - Order: Q[15:12], Q[11:8], Q[7:4], Q[3:0], I[15:12], I[11:8], I[7:4], I[3:0].
  - Once nib_cnt=7 has been presented, return to IDLE.
- SEND_STAT: present the status nibble for one cycle, then return to IDLE.
- IDLE: DATA_OUT=0.
- otr_s is set in any cycle with ADC_OTR=1.
- iq_avail and fifo_level are registered from the post-update occupancy.

## Timing
- Command at edge N (DATA_SYNC sampled high) → first nibble on DATA_OUT after edge N+1.
- RX-IQ: nibble k is valid after edge N+1+k, for k=0..7. DATA_OUT=0 after edge N+9.
- Status: nibble valid after edge N+1; 0 after edge N+2.
- The STM32 must not assert DATA_SYNC sooner than 9 cycles after an RX-IQ command or 2 cycles after a status command; an earlier strobe aborts the transfer as above.
- Pop occurs at edge N+1. iq_avail and fifo_level reflect it after edge N+2.
- A push at edge M is reflected in iq_avail and fifo_level after edge M+1.
- rst=1 at any edge forces reset values at that edge, including mid-transfer and with the FIFO full; FIFO contents are discarded.

## Structure
- Package stm32_if_pkg:
  - Command codes: 1=params-in, 2=status, 3=TX IQ, 4=RX IQ.
  - Status bit positions: 0=otr, 1=ovf, 2=udr.
  - The state enum.
  - Nibble count NIBS_PER_IQ=8.
- Sub-module iq_sync_fifo:
  - Single-clock, WIDTH=32, DEPTH=FIFO_DEPTH.
  - Registered full, empty and level outputs.
  - Simultaneous push and pop permitted when full.
- The scheduler holds the command decode, the state machine, the hold register and the sticky flags.

## Test plan
- Reset, push one sample I=16'h1234, Q=16'hABCD, issue CMD_RX_IQ → DATA_OUT sequence A,B,C,D,1,2,3,4 on cycles N+1..N+8; iq_avail falls after N+2; then DATA_OUT=0.
- Empty FIFO, CMD_RX_IQ → eight 0 nibbles; a following CMD_STATUS returns 4'b0100; a second CMD_STATUS returns 4'b0000.
- 17 pushes with depth 16 and no reads → fifo_level=16; CMD_STATUS returns 4'b0010; the first 16 samples read back in order.
- ADC_OTR pulsed one cycle, then CMD_STATUS → 4'b0001. ADC_OTR held high during the clear cycle → the next status read also returns 4'b0001.
- CMD_RX_IQ, then CMD_STATUS at N+3 → nibbles Q[15:12], Q[11:8] only, then the status nibble at N+4; the next CMD_RX_IQ returns the following sample.
- rst asserted at nibble 4 with 5 samples queued → DATA_OUT=0, fifo_level=0, iq_avail=0 after that edge.
